// File: rtl/gc_pkg.sv
// Shared types and helpers for the Gray-to-binary tracker and anything that decodes its links.
package gc_pkg;

    localparam int unsigned DEF_WIDTH       = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned GC_MAX_W        = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } gc_state_e;

    // Zero-extended Gray decodes to the zero-extended binary, so one wide function serves all widths.
    function automatic logic [GC_MAX_W-1:0] gray2bin(input logic [GC_MAX_W-1:0] g);
        logic [GC_MAX_W-1:0] b;
        b[GC_MAX_W-1] = g[GC_MAX_W-1];
        for (int i = int'(GC_MAX_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gc_sync.sv
// Multi-stage reset-to-0 synchroniser for an asynchronous bus.
module gc_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = async_in;
        for (int i = 1; i < int'(STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/gc_to_bin_tracker.sv
// Synchronises a Gray-coded bus, decodes it, and tracks position with a binary adjacency check.
module gc_to_bin_tracker
    import gc_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Gc_input,
    input  logic             sample_en,
    input  logic             clear_err,
    output logic [WIDTH-1:0] Bin_output,
    output logic             valid_out,
    output logic             step,
    output logic             dir_up,
    output logic             err,
    output logic [CNT_W-1:0] pos_count
);

    logic [WIDTH-1:0] g_sync;
    logic [WIDTH-1:0] b_c;
    logic [WIDTH-1:0] diff_c;

    gc_state_e        state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;
    logic             step_q, step_d;
    logic             dir_up_q, dir_up_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] pos_q, pos_d;

    gc_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (Gc_input),
        .sync_out (g_sync)
    );

    assign b_c    = WIDTH'(gray2bin(GC_MAX_W'(g_sync)));
    // Modular difference: 1 is an up step, all-ones a down step, including across the wrap.
    assign diff_c = b_c - bin_q;

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        valid_d  = valid_q;
        step_d   = 1'b0;
        dir_up_d = dir_up_q;
        err_d    = err_q;
        pos_d    = pos_q;

        case (state_q)
            IDLE: begin
                if (sample_en) begin
                    bin_d   = b_c;
                    valid_d = 1'b1;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (sample_en) begin
                    if (diff_c == WIDTH'(1)) begin
                        bin_d    = b_c;
                        step_d   = 1'b1;
                        dir_up_d = 1'b1;
                        pos_d    = pos_q + CNT_W'(1);
                    end else if (diff_c == {WIDTH{1'b1}}) begin
                        bin_d    = b_c;
                        step_d   = 1'b1;
                        dir_up_d = 1'b0;
                        pos_d    = pos_q - CNT_W'(1);
                    end else if (diff_c != WIDTH'(0)) begin
                        err_d    = 1'b1;
                        valid_d  = 1'b0;
                        state_d  = FAULT;
                    end
                end
            end
            FAULT: begin
                if (clear_err) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            valid_q  <= 1'b0;
            step_q   <= 1'b0;
            dir_up_q <= 1'b0;
            err_q    <= 1'b0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            valid_q  <= valid_d;
            step_q   <= step_d;
            dir_up_q <= dir_up_d;
            err_q    <= err_d;
            pos_q    <= pos_d;
        end
    end

    assign Bin_output = bin_q;
    assign valid_out  = valid_q;
    assign step       = step_q;
    assign dir_up     = dir_up_q;
    assign err        = err_q;
    assign pos_count  = pos_q;

endmodule
